mycpu_if_fetch: RTL and testbench
=================================

Name: mycpu_if_fetch

Overview:
- Parametrised instruction-fetch front end for the myCPU pipeline, sitting between the PC/redirect logic and the ID stage.
- Issues pipelined requests to the instruction memory over a request/grant + in-order response interface, keeping up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions with their PCs in a FIFO of FIFO_DEPTH entries, presented to ID over a valid/ready handshake.
- Handles relative and absolute redirects: flushes the buffer and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'hbfc00000, first fetch address after reset.
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, ≥2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..FIFO_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  redirect this cycle.
- redirect_abs  in  1  1: target = redirect_offset; 0: target = redirect_base + 4 + redirect_offset.
- redirect_base  in  ADDR_W  PC of the redirecting instruction.
- redirect_offset  in  ADDR_W  offset or absolute target.
- inst_req  out  1  request valid.
- inst_addr  out  ADDR_W  request address (= fetch_pc).
- inst_gnt  in  1  request accepted when inst_req && inst_gnt.
- inst_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- inst_rdata  in  DATA_W  response instruction.
- id_valid  out  1  buffer head valid.
- id_inst  out  DATA_W  head instruction.
- id_pc  out  ADDR_W  head PC.
- id_ready  in  1  ID accepts head when id_valid && id_ready.

Behaviour:
- Reset values: fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard=0, FIFO empty; inst_req=0, id_valid=0, inst_addr=RESET_PC, id_pc=RESET_PC, id_inst=0.
- Reset mid-operation: all state cleared immediately; in-flight responses arriving after reset release are treated as valid new responses. The memory side must also be reset.
- Issue: inst_req = !rst_q && !redirect_valid && (outstanding < MAX_OUTSTANDING) && (outstanding + fifo_count < FIFO_DEPTH).
  - rst_q is a flop set by rst and cleared on the first clk edge after release, so inst_req first asserts in the 2nd cycle after release.
  - The credit check counts discard entries as outstanding, so the FIFO can never overflow.
- Grant fire: fetch_pc <= fetch_pc + 4 (wraps modulo 2^ADDR_W); outstanding += 1.
- Response: outstanding -= 1.
  - If discard > 0: discard -= 1; data is dropped.
  - Otherwise: push {resp_pc, inst_rdata}; resp_pc += 4.
- Latency: response in cycle N → id_valid in cycle N+1 (registered FIFO, no bypass).
- Pop: on id_valid && id_ready, advance the head. Simultaneous push and pop is allowed at any count, including full.
- Redirect, highest priority:
  - target = computed address with bits [1:0] forced to 0.
  - fetch_pc <= target; resp_pc <= target.
  - FIFO flushed next cycle. A pop in the redirect cycle still completes; other entries are lost.
  - No request is issued in the redirect cycle.
  - discard <= outstanding_next, i.e. (outstanding − rvalid). A response arriving in the redirect cycle is itself dropped.
- Back-to-back redirects: the last one wins; discard recomputed each time.
- Counter widths: $clog2(FIFO_DEPTH)+1 bits.
- Invariants (assert in bench): discard ≤ outstanding ≤ MAX_OUTSTANDING; outstanding + fifo_count ≤ FIFO_DEPTH.

Test Plan:
- Reset release, inst_gnt=1, memory latency 1, id_ready=1 → inst_addr 0xbfc00000, 0xbfc00004, 0xbfc00008… on consecutive cycles. First id_valid with id_pc=0xbfc00000 two cycles after its grant.
- id_ready=0 with FIFO_DEPTH=4 → exactly 4 grants total; inst_req stays low; id_pc/id_inst hold 0xbfc00000. Releasing id_ready resumes fetch at 0xbfc00010.
- Relative redirect, base=0xbfc00010, offset=0x20, with 2 requests outstanding → next inst_addr=0xbfc00034; the two stale responses never appear on id_*; the next id_pc=0xbfc00034.
- Absolute redirect to 0x80000003 while FIFO holds 3 entries and id_ready=1 → head popped that cycle, rest flushed; next fetch and id_pc = 0x80000000.
- Response arriving in the same cycle as a redirect, plus a second redirect one cycle later → all pre-redirect data dropped; only instructions from the second target delivered.
- Random inst_gnt/inst_rvalid delays (0–5 cycles) with random id_ready → id_pc strictly +4 between redirects; invariants never violated; assert rst mid-burst → inst_req=0, id_valid=0 immediately, restart at 0xbfc00000.

Source files
------------

// File: rtl/mycpu_if_fetch.sv
// Instruction-fetch front end: pipelined imem requests, in-order responses,
// a small instruction/PC buffer towards ID, and redirect flush/discard.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   redirect_valid/abs        redirect strobe, absolute (1) or relative (0)
//   redirect_base/offset      relative: base+4+offset, absolute: offset
//   inst_req/addr/gnt         imem request channel (fires on req && gnt)
//   inst_rvalid/rdata         imem in-order response channel
//   id_valid/inst/pc/ready    buffer head towards ID (fires on valid && ready)
module mycpu_if_fetch #(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter logic [ADDR_W-1:0] RESET_PC        = 32'hbfc00000,
    parameter int                FIFO_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic              redirect_abs,
    input  logic [ADDR_W-1:0] redirect_base,
    input  logic [ADDR_W-1:0] redirect_offset,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_gnt,
    input  logic              inst_rvalid,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_O   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_S = (CW+1)'(FIFO_DEPTH);

    logic              rst_q;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     fifo_count;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [DATA_W-1:0] inst_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

    logic [CW:0]       credit_sum;
    logic [CW-1:0]     outstanding_next;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] redirect_target;
    logic              issue;
    logic              push;
    logic              pop;
    logic              drop;

    // Requests in flight (including ones to be discarded) reserve buffer
    // slots, so a response always has room when it lands.
    always_comb begin
        credit_sum       = {1'b0, outstanding} + {1'b0, fifo_count};
        inst_req         = !rst_q && !redirect_valid
                           && (outstanding < MAX_O)
                           && (credit_sum < DEPTH_S);
        inst_addr        = fetch_pc;
        issue            = inst_req && inst_gnt;
        drop             = discard != '0;
        push             = inst_rvalid && !drop && !redirect_valid;
        id_valid         = fifo_count != '0;
        pop              = id_valid && id_ready;
        id_inst          = inst_mem[rd_ptr];
        id_pc            = pc_mem[rd_ptr];
        outstanding_next = outstanding + CW'(issue) - CW'(inst_rvalid);
        raw_target       = redirect_abs ? redirect_offset
                           : redirect_base + ADDR_W'(32'd4) + redirect_offset;
        redirect_target  = raw_target & ~ADDR_W'(32'd3);
    end

    // Holds issue off for the first cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_q <= 1'b1;
        else     rst_q <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale.
                fetch_pc   <= redirect_target;
                resp_pc    <= redirect_target;
                discard    <= outstanding_next;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + ADDR_W'(32'd4);
                if (inst_rvalid && drop) discard <= discard - CW'(1'b1);
                if (push) begin
                    resp_pc <= resp_pc + ADDR_W'(32'd4);
                    wr_ptr  <= wr_ptr + PW'(1'b1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1'b1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= RESET_PC;
            end
        end else if (push) begin
            inst_mem[wr_ptr] <= inst_rdata;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_mycpu_if_fetch.sv
// Bench for mycpu_if_fetch: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_mycpu_if_fetch;

    localparam logic [31:0] RST_PC = 32'hbfc00000;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic        redirect_abs = 1'b0;
    logic [31:0] redirect_base = '0;
    logic [31:0] redirect_offset = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt = 1'b0;
    logic        inst_rvalid = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;

    mycpu_if_fetch dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_abs(redirect_abs),
        .redirect_base(redirect_base), .redirect_offset(redirect_offset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        bit          rdy;
        bit          rv;
        bit          ab;
        logic [31:0] base;
        logic [31:0] off;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
    } vec_t;

    mreq_t mq[$];
    ent_t  q[$];
    logic [31:0] exp_fetch, seq_pc;
    int tests = 0, fails = 0, cyc = 0, grants;
    bit obs_req, obs_vld;
    logic [31:0] obs_addr, obs_pc, obs_inst;
    vec_t vecs[9];

    function automatic logic [31:0] hsh(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hdeadbeef;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        inst_rvalid = 1'b0; inst_gnt = 1'b0;
        redirect_valid = 1'b0; id_ready = 1'b0;
        #1;
        chk("rst_req", inst_req, 0);
        chk("rst_vld", id_valid, 0);
        chk("rst_addr", inst_addr, RST_PC);
        chk("rst_pc", id_pc, RST_PC);
        chk("rst_inst", id_inst, 0);
        mq.delete(); q.delete();
        exp_fetch = RST_PC; seq_pc = RST_PC;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_req", inst_req, 0);
    endtask

    task automatic cycle(input bit gnt, input bit rdy, input bit rv,
                         input bit ab, input logic [31:0] base,
                         input logic [31:0] off, input int lat_max);
        bit resp, exp_req;
        logic [31:0] tgt;
        mreq_t m;
        @(negedge clk);
        cyc++;
        resp = mq.size() != 0 && mq[0].due <= cyc;
        inst_gnt = gnt; id_ready = rdy;
        redirect_valid = rv; redirect_abs = ab;
        redirect_base = base; redirect_offset = off;
        inst_rvalid = resp;
        inst_rdata = resp ? hsh(mq[0].addr) : $urandom;
        #1;
        obs_req = inst_req; obs_addr = inst_addr;
        obs_vld = id_valid; obs_pc = id_pc; obs_inst = id_inst;
        exp_req = !rv && mq.size() < MAXO && mq.size() + q.size() < DEPTH;
        chk("req", inst_req, exp_req);
        if (inst_req) chk("addr", inst_addr, exp_fetch);
        chk("id_valid", id_valid, q.size() != 0);
        if (id_valid && q.size() != 0) begin
            chk("id_pc", id_pc, q[0].pc);
            chk("id_inst", id_inst, q[0].inst);
        end
        if (id_valid && id_ready && q.size() != 0) begin
            chk("seq_pc", id_pc, seq_pc);
            seq_pc = seq_pc + 4;
            void'(q.pop_front());
        end
        if (resp) begin
            m = mq.pop_front();
            if (!rv && !m.stale) q.push_back('{m.addr, hsh(m.addr)});
        end
        if (rv) begin
            tgt = (ab ? off : base + 32'd4 + off) & ~32'd3;
            exp_fetch = tgt; seq_pc = tgt;
            q.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
        end else if (inst_req && gnt) begin
            mq.push_back('{exp_fetch, cyc + 1 + int'($urandom_range(0, lat_max)), 1'b0});
            exp_fetch = exp_fetch + 4;
        end
        chk("inv_out", mq.size() <= MAXO, 1);
        chk("inv_sum", mq.size() + q.size() <= DEPTH, 1);
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 0, 0, 1, 32'hbfc00000, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 0, 1, 32'hbfc00004, 0, 0};
        vecs[2] = '{1, 0, 0, 0, 0, 1, 32'hbfc00008, 1, 32'hbfc00000};
        vecs[3] = '{1, 0, 0, 0, 0, 1, 32'hbfc0000c, 1, 32'hbfc00004};
        vecs[4] = '{1, 0, 0, 0, 0, 1, 32'hbfc00010, 1, 32'hbfc00008};
        vecs[5] = '{1, 1, 0, 32'hbfc00010, 32'h20, 0, 0, 1, 32'hbfc0000c};
        vecs[6] = '{1, 0, 0, 0, 0, 1, 32'hbfc00034, 0, 0};
        vecs[7] = '{1, 0, 0, 0, 0, 1, 32'hbfc00038, 0, 0};
        vecs[8] = '{1, 0, 0, 0, 0, 1, 32'hbfc0003c, 1, 32'hbfc00034};

        do_reset();
        foreach (vecs[i]) begin
            cycle(1, vecs[i].rdy, vecs[i].rv, vecs[i].ab,
                  vecs[i].base, vecs[i].off, 0);
            chk("tbl_req", obs_req, vecs[i].e_req);
            if (vecs[i].e_req) chk("tbl_addr", obs_addr, vecs[i].e_addr);
            chk("tbl_vld", obs_vld, vecs[i].e_vld);
            if (vecs[i].e_vld) chk("tbl_pc", obs_pc, vecs[i].e_pc);
        end

        // Backpressure: buffer fills after exactly four grants.
        do_reset();
        grants = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
            if (obs_req) grants++;
        end
        chk("bp_grants", grants, 4);
        chk("bp_req", obs_req, 0);
        chk("bp_pc", obs_pc, RST_PC);
        chk("bp_inst", obs_inst, hsh(RST_PC));
        obs_req = 0;
        for (int k = 0; k < 10 && !obs_req; k++) cycle(1, 1, 0, 0, 0, 0, 0);
        chk("bp_resume", obs_addr, 32'hbfc00010);

        // Relative redirect with two requests in flight.
        for (int k = 0; k < 20 && mq.size() != 2; k++)
            cycle(1, 1, 0, 0, 0, 0, 3);
        chk("rel_outst", mq.size(), 2);
        cycle(1, 1, 1, 0, 32'hbfc00010, 32'h20, 3);
        obs_req = 0;
        for (int k = 0; k < 20 && !obs_req; k++) cycle(1, 1, 0, 0, 0, 0, 3);
        chk("rel_addr", obs_addr, 32'hbfc00034);
        obs_vld = 0;
        for (int k = 0; k < 20 && !obs_vld; k++) cycle(1, 1, 0, 0, 0, 0, 3);
        chk("rel_pc", obs_pc, 32'hbfc00034);

        // Absolute redirect with three buffered entries and a pop.
        for (int k = 0; k < 20 && q.size() != 3; k++)
            cycle(1, 0, 0, 0, 0, 0, 0);
        chk("abs_fill", q.size(), 3);
        cycle(1, 1, 1, 1, 0, 32'h80000003, 0);
        chk("abs_pop", obs_vld, 1);
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("abs_flush", obs_vld, 0);
        for (int k = 0; k < 20 && !obs_req; k++) cycle(1, 1, 0, 0, 0, 0, 0);
        chk("abs_addr", obs_addr, 32'h80000000);
        obs_vld = 0;
        for (int k = 0; k < 20 && !obs_vld; k++) cycle(1, 1, 0, 0, 0, 0, 0);
        chk("abs_pc", obs_pc, 32'h80000000);

        // Redirect with a response landing, then another redirect.
        repeat (4) cycle(1, 1, 0, 0, 0, 0, 0);
        chk("dbl_resp", mq.size() != 0 && mq[0].due <= cyc + 1, 1);
        cycle(1, 1, 1, 1, 0, 32'h00001000, 0);
        cycle(1, 1, 1, 1, 0, 32'h00002000, 0);
        obs_vld = 0;
        for (int k = 0; k < 20 && !obs_vld; k++) cycle(1, 1, 0, 0, 0, 0, 0);
        chk("dbl_pc", obs_pc, 32'h00002000);

        // Randomized traffic with a reset in the middle of a burst.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 255), 5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
